// File: rtl/parity_stream_checker.sv
// Parity checker for a stream of DATA_W-bit words with one parity bit each.
// Produces a registered per-word error flag, a saturating error counter,
// a sticky error bit, and an error summary for each FRAME_LEN-word frame.
module parity_stream_checker #(
  parameter int DATA_W    = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              odd_sel,
  input  logic              clr,
  output logic              out_valid,
  output logic              word_err,
  output logic              frame_done,
  output logic              frame_err,
  output logic [IDX_W-1:0]  word_idx,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sticky_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic             acc, acc_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             fdone_nxt, ferr_nxt;
  logic             err, last, acc_in;

  // Odd parity: total ones (data + parity) must be odd; even: must be even.
  assign err    = odd_sel ? ~(^{in_data, in_parity}) : (^{in_data, in_parity});
  assign last   = (word_idx == LAST_IDX);
  // A frame that has not started yet carries no accumulated error.
  assign acc_in = (state == ACCUM) & acc;

  // Frame FSM next state: advance index and accumulate on each accepted word;
  // clr discards the current frame including the word accepted with it.
  always_comb begin
    state_nxt = state;
    idx_nxt   = word_idx;
    acc_nxt   = acc;
    fdone_nxt = 1'b0;
    ferr_nxt  = frame_err;
    if (clr) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      acc_nxt   = 1'b0;
    end else if (in_valid) begin
      if (last) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        acc_nxt   = 1'b0;
        fdone_nxt = 1'b1;
        ferr_nxt  = acc_in | err;
      end else begin
        state_nxt = ACCUM;
        idx_nxt   = word_idx + IDX_W'(1);
        acc_nxt   = acc_in | err;
      end
    end
  end

  // Frame state and frame-level outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_idx   <= '0;
      acc        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_idx   <= idx_nxt;
      acc        <= acc_nxt;
      frame_done <= fdone_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  // Per-word result: one-cycle valid pulse, error flag held between words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      word_err  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) word_err <= err;
    end
  end

  // Error statistics: saturating count and sticky flag; clr wins over a same-cycle error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (clr) begin
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (in_valid && err) begin
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
      sticky_err <= 1'b1;
    end
  end

endmodule
